// File: rtl/store_buffer.sv
// Store buffer: a FIFO of pending {addr, data} stores that drains into data
// memory when commit_en allows, and forwards the newest matching store to loads.
module store_buffer #(
  parameter int DEPTH    = 4,
  parameter int ADDR_MAX = 65535
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  output logic                       rsp_valid,
  output logic [31:0]                rsp_rdata,
  input  logic                       commit_en,
  output logic [31:0]                mem_read_address,
  input  logic [31:0]                mem_data_out,
  output logic [31:0]                mem_write_address,
  output logic [31:0]                mem_data_in,
  output logic                       mem_write_enable,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0]   ADDR_LIMIT = 32'(ADDR_MAX);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          err_q, err_d;

  logic          accept_s;
  logic          in_range_s;
  logic          push_s;
  logic          pop_s;
  logic          fwd_hit_s;
  logic [31:0]   fwd_data_s;
  logic [PW-1:0] fwd_idx_s;

  // Handshake and commit qualifiers; nothing is accepted or written while in reset
  always_comb begin
    req_ready  = (count_q < DEPTH_C);
    accept_s   = rst_n & req_valid & req_ready;
    in_range_s = (req_addr <= ADDR_LIMIT);
    push_s     = accept_s & req_we & in_range_s;
    pop_s      = rst_n & commit_en & (count_q != {CW{1'b0}});
  end

  // Scan oldest to newest so the last match wins; the committing head is still scanned
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = 32'h0;
    fwd_idx_s  = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s = head_q + PW'(i);
      if ((CW'(i) < count_q) && valid_q[fwd_idx_s] && (addr_q[fwd_idx_s] == req_addr)) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = data_q[fwd_idx_s];
      end else begin
        fwd_hit_s  = fwd_hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  // FIFO pointer, entry and response next-state
  always_comb begin
    addr_d      = addr_q;
    data_d      = data_q;
    valid_d     = valid_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    rsp_valid_d = accept_s & ~req_we;
    rsp_rdata_d = rsp_rdata_q;
    err_d       = accept_s & ~in_range_s;

    if (push_s) begin
      addr_d[tail_q]  = req_addr;
      data_d[tail_q]  = req_wdata;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      tail_d = tail_q;
    end

    if (pop_s) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      head_d = head_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase

    if (accept_s && !req_we) begin
      if (!in_range_s) begin
        rsp_rdata_d = 32'h0;
      end else if (fwd_hit_s) begin
        rsp_rdata_d = fwd_data_s;
      end else begin
        rsp_rdata_d = mem_data_out;
      end
    end else begin
      rsp_rdata_d = rsp_rdata_q;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 32'h0;
        data_q[i] <= 32'h0;
      end
      valid_q     <= {DEPTH{1'b0}};
      head_q      <= {PW{1'b0}};
      tail_q      <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
    end
  end

  // Memory ports are driven straight from the head entry and the request address
  always_comb begin
    mem_read_address  = req_addr;
    mem_write_enable  = pop_s;
    mem_write_address = addr_q[head_q];
    mem_data_in       = data_q[head_q];
    count             = count_q;
    rsp_valid         = rsp_valid_q;
    rsp_rdata         = rsp_rdata_q;
    err               = err_q;
  end

endmodule
